// File: rtl/seg7_pattern_decoder_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : seg7_pattern_decoder_pkg
//  Description : Shared 7-segment glyph table (active-high, abcdefg order,
//                a = bit 6) plus common types for the pattern decoder.
//  Revision    : 1.0  initial release
// ============================================================================
package seg7_pattern_decoder_pkg;

    localparam logic [6:0] SEG_0 = 7'b1111110;
    localparam logic [6:0] SEG_1 = 7'b0110000;
    localparam logic [6:0] SEG_2 = 7'b1101101;
    localparam logic [6:0] SEG_3 = 7'b1111001;
    localparam logic [6:0] SEG_4 = 7'b0110011;
    localparam logic [6:0] SEG_5 = 7'b1011011;
    localparam logic [6:0] SEG_6 = 7'b1011111;
    localparam logic [6:0] SEG_7 = 7'b1110000;
    localparam logic [6:0] SEG_8 = 7'b1111111;
    localparam logic [6:0] SEG_9 = 7'b1111011;
    localparam logic [6:0] SEG_A = 7'b1110111;
    localparam logic [6:0] SEG_B = 7'b0011111;
    localparam logic [6:0] SEG_C = 7'b1001110;
    localparam logic [6:0] SEG_D = 7'b0111101;
    localparam logic [6:0] SEG_E = 7'b1001111;
    localparam logic [6:0] SEG_F = 7'b1000111;

    localparam int unsigned CNT_W = 4;

    typedef logic [CNT_W-1:0] stab_cnt_t;

endpackage : seg7_pattern_decoder_pkg
`default_nettype wire

// File: rtl/seg7_pattern_decoder_glyph_lookup.sv
`default_nettype none
// ============================================================================
//  Module      : seg7_glyph_lookup
//  Description : Combinational map from an active-high abcdefg pattern to its
//                hex value and a legal-glyph flag.
//  Revision    : 1.0  initial release
// ============================================================================
module seg7_glyph_lookup
    import seg7_pattern_decoder_pkg::*;
(
    input  logic [6:0] i_pattern,
    output logic [3:0] o_value,
    output logic       o_legal
);

    always_comb begin
        o_value = 4'h0;
        o_legal = 1'b1;
        case (i_pattern)
            SEG_0:   o_value = 4'h0;
            SEG_1:   o_value = 4'h1;
            SEG_2:   o_value = 4'h2;
            SEG_3:   o_value = 4'h3;
            SEG_4:   o_value = 4'h4;
            SEG_5:   o_value = 4'h5;
            SEG_6:   o_value = 4'h6;
            SEG_7:   o_value = 4'h7;
            SEG_8:   o_value = 4'h8;
            SEG_9:   o_value = 4'h9;
            SEG_A:   o_value = 4'hA;
            SEG_B:   o_value = 4'hB;
            SEG_C:   o_value = 4'hC;
            SEG_D:   o_value = 4'hD;
            SEG_E:   o_value = 4'hE;
            SEG_F:   o_value = 4'hF;
            default: o_legal = 1'b0;
        endcase
    end

endmodule : seg7_glyph_lookup
`default_nettype wire

// File: rtl/seg7_pattern_decoder.sv
`default_nettype none
// ============================================================================
//  Module      : seg7_pattern_decoder
//  Description : Reads back a 7-segment drive bus, debounces it on the sample
//                tick and reports the committed hex digit and legality.
//  Revision    : 1.0  initial release
// ============================================================================
module seg7_pattern_decoder
    import seg7_pattern_decoder_pkg::*;
#(
    parameter bit          ACTIVE_LOW = 1'b1,
    parameter int unsigned STABLE_CNT = 4
) (
    input  logic       CLOCK_50,
    input  logic       reset,
    input  logic       sample_en,
    input  logic [1:7] seg,
    output logic [3:0] digit,
    output logic       valid,
    output logic       illegal,
    output logic       changed
);

    localparam logic [6:0] c_ALL_OFF = ACTIVE_LOW ? 7'h7F : 7'h00;
    localparam stab_cnt_t  c_STABLE  = stab_cnt_t'(STABLE_CNT);

    logic [6:0] r_sync1;
    logic [6:0] r_sync2;
    logic [6:0] r_prev;
    stab_cnt_t  r_cnt;
    logic [3:0] r_digit;
    logic       r_valid;
    logic       r_illegal;
    logic       r_changed;

    logic [6:0] w_norm;
    logic       w_diff;
    stab_cnt_t  w_cnt_next;
    logic       w_commit;
    logic [3:0] w_lut_value;
    logic       w_lut_legal;

    assign w_norm = ACTIVE_LOW ? ~r_sync2 : r_sync2;
    assign w_diff = (w_norm != r_prev);

    always_comb begin
        w_cnt_next = r_cnt;
        if (w_diff)
            w_cnt_next = stab_cnt_t'(1);
        else if (r_cnt != c_STABLE)
            w_cnt_next = r_cnt + stab_cnt_t'(1);
    end

    // A saturated counter only re-commits when a new pattern restarts the run
    // (which with a threshold of one is immediately).
    assign w_commit = sample_en && (w_cnt_next == c_STABLE) &&
                      (w_diff || (r_cnt != c_STABLE));

    seg7_glyph_lookup u_lookup (
        .i_pattern (w_norm),
        .o_value   (w_lut_value),
        .o_legal   (w_lut_legal)
    );

    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            r_sync1   <= c_ALL_OFF;
            r_sync2   <= c_ALL_OFF;
            r_prev    <= 7'h00;
            r_cnt     <= '0;
            r_digit   <= 4'h0;
            r_valid   <= 1'b0;
            r_illegal <= 1'b0;
            r_changed <= 1'b0;
        end else begin
            r_sync1   <= seg;
            r_sync2   <= r_sync1;
            r_changed <= 1'b0;
            if (sample_en) begin
                r_prev <= w_norm;
                r_cnt  <= w_cnt_next;
            end
            if (w_commit) begin
                if (w_lut_legal) begin
                    r_digit   <= w_lut_value;
                    r_valid   <= 1'b1;
                    r_illegal <= 1'b0;
                    r_changed <= (w_lut_value != r_digit) || !r_valid;
                end else begin
                    r_valid   <= 1'b0;
                    r_illegal <= 1'b1;
                    r_changed <= r_valid;
                end
            end
        end
    end

    assign digit   = r_digit;
    assign valid   = r_valid;
    assign illegal = r_illegal;
    assign changed = r_changed;

endmodule : seg7_pattern_decoder
`default_nettype wire

// File: tb/tb_seg7_pattern_decoder.sv
`default_nettype none
// ============================================================================
//  Module      : tb_seg7_pattern_decoder
//  Description : Scoreboard bench for seg7_pattern_decoder (active-low, 4-sample
//                instance and active-high, 1-sample instance).
//  Revision    : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
module tb_seg7_pattern_decoder;

    logic       clk = 1'b0;
    logic       rst;
    logic       se1, se2;
    logic [1:7] seg1, seg2;
    logic [3:0] dig1, dig2;
    logic       val1, val2, ill1, ill2, chg1, chg2;

    logic [5:0] q1[$];
    logic [5:0] q2[$];
    logic [5:0] e1, e2;
    int         n_cmp = 0;
    int         n_bad = 0;
    int         pulses1 = 0;
    int         pulses2 = 0;
    int         base;
    logic       walk_on = 1'b0;
    logic       saw_ill = 1'b0;

    always #10 clk = ~clk;

    seg7_pattern_decoder #(.ACTIVE_LOW(1'b1), .STABLE_CNT(4)) u_dut1 (
        .CLOCK_50 (clk), .reset (rst), .sample_en (se1), .seg (seg1),
        .digit (dig1), .valid (val1), .illegal (ill1), .changed (chg1)
    );

    seg7_pattern_decoder #(.ACTIVE_LOW(1'b0), .STABLE_CNT(1)) u_dut2 (
        .CLOCK_50 (clk), .reset (rst), .sample_en (se2), .seg (seg2),
        .digit (dig2), .valid (val2), .illegal (ill2), .changed (chg2)
    );

    function automatic logic [6:0] glyph(input int i);
        case (i)
            0:  glyph = 7'b1111110;  1:  glyph = 7'b0110000;
            2:  glyph = 7'b1101101;  3:  glyph = 7'b1111001;
            4:  glyph = 7'b0110011;  5:  glyph = 7'b1011011;
            6:  glyph = 7'b1011111;  7:  glyph = 7'b1110000;
            8:  glyph = 7'b1111111;  9:  glyph = 7'b1111011;
            10: glyph = 7'b1110111;  11: glyph = 7'b0011111;
            12: glyph = 7'b1001110;  13: glyph = 7'b0111101;
            14: glyph = 7'b1001111;  default: glyph = 7'b1000111;
        endcase
    endfunction

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Monitor: every changed pulse must match the oldest queued expectation.
    always @(negedge clk) begin
        if (walk_on && ill1) saw_ill = 1'b1;
        if (!rst && chg1 === 1'b1) begin
            pulses1++;
            if (q1.size() == 0) begin
                n_cmp++; n_bad++;
                $display("FAIL dut1_unexpected_pulse: got digit=%0h valid=%0b illegal=%0b, expected no pulse",
                         dig1, val1, ill1);
            end else begin
                e1 = q1.pop_front();
                check("dut1_commit {digit,valid,illegal}", 32'({dig1, val1, ill1}), 32'(e1));
            end
        end
        if (!rst && chg2 === 1'b1) begin
            pulses2++;
            if (q2.size() == 0) begin
                n_cmp++; n_bad++;
                $display("FAIL dut2_unexpected_pulse: got digit=%0h valid=%0b illegal=%0b, expected no pulse",
                         dig2, val2, ill2);
            end else begin
                e2 = q2.pop_front();
                check("dut2_commit {digit,valid,illegal}", 32'({dig2, val2, ill2}), 32'(e2));
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        rst  = 1'b1;
        se1  = 1'b1;
        se2  = 1'b1;
        seg1 = 7'b1111111;
        seg2 = 7'b0000000;
        repeat (3) step();
        check("reset_digit",   32'(dig1), 0);
        check("reset_valid",   32'(val1), 0);
        check("reset_illegal", 32'(ill1), 0);
        check("reset_changed", 32'(chg1), 0);
        rst = 1'b0;

        // Blank bus is an illegal glyph; commits silently from the reset state.
        repeat (8) step();
        check("blank_illegal",      32'({dig1, val1, ill1}), 32'({4'h0, 1'b0, 1'b1}));
        check("blank_illegal_dut2", 32'({dig2, val2, ill2}), 32'({4'h0, 1'b0, 1'b1}));

        // "1" on the active-low bus: 2 sync + 4 samples.
        q1.push_back({4'h1, 1'b1, 1'b0});
        seg1 = ~glyph(1);
        repeat (5) step();
        check("one_latency_early", 32'(val1), 0);
        step();
        check("one_digit",   32'(dig1), 1);
        check("one_valid",   32'(val1), 1);
        check("one_changed", 32'(chg1), 1);
        step();
        check("one_pulse_width", 32'(chg1), 0);
        repeat (4) step();

        // Stable "7", 3-sample glitch to "8", back to "7".
        q1.push_back({4'h7, 1'b1, 1'b0});
        seg1 = ~glyph(7);
        repeat (8) step();
        check("seven_digit", 32'(dig1), 7);
        seg1 = ~glyph(8);
        repeat (3) step();
        seg1 = ~glyph(7);
        repeat (10) step();
        check("glitch_digit", 32'(dig1), 7);
        check("glitch_valid", 32'(val1), 1);

        // Illegal pattern keeps the old digit.
        q1.push_back({4'h7, 1'b0, 1'b1});
        seg1 = ~7'b1010101;
        repeat (8) step();
        check("illegal_state", 32'({dig1, val1, ill1}), 32'({4'h7, 1'b0, 1'b1}));

        // Asynchronous reset in mid-cycle while "5" is being debounced.
        seg1 = ~glyph(5);
        repeat (3) step();
        #4 rst = 1'b1;
        #1;
        check("async_reset_outputs", 32'({dig1, val1, ill1, chg1}), 0);
        @(posedge clk);
        #1 rst = 1'b0;
        q1.push_back({4'h5, 1'b1, 1'b0});
        repeat (5) step();
        check("five_latency_early", 32'(val1), 0);
        step();
        check("five_after_reset", 32'({dig1, val1, chg1}), 32'({4'h5, 1'b1, 1'b1}));
        repeat (4) step();

        // Walk all 16 glyphs with a 1-in-8 sample tick, 5 ticks per glyph.
        base    = pulses1;
        walk_on = 1'b1;
        for (int g = 0; g < 16; g++) begin
            q1.push_back({4'(g), 1'b1, 1'b0});
            seg1 = ~glyph(g);
            for (int k = 0; k < 40; k++) begin
                se1 = (k % 8 == 0);
                step();
            end
            check($sformatf("walk_digit_%0d", g), 32'(dig1), g);
        end
        walk_on = 1'b0;
        check("walk_pulses", pulses1 - base, 16);
        check("walk_no_illegal", 32'(saw_ill), 0);

        // Sample enable low freezes everything.
        se1  = 1'b0;
        seg1 = ~glyph(2);
        repeat (20) step();
        check("frozen_digit", 32'(dig1), 15);
        q1.push_back({4'h2, 1'b1, 1'b0});
        se1 = 1'b1;
        repeat (3) step();
        check("unfrozen_early", 32'(dig1), 15);
        step();
        check("unfrozen_digit", 32'(dig1), 2);

        // STABLE_CNT=1, active-high: held glyph commits once.
        base = pulses2;
        q2.push_back({4'h3, 1'b1, 1'b0});
        seg2 = glyph(3);
        repeat (20) step();
        check("dut2_hold_digit",  32'(dig2), 3);
        check("dut2_hold_pulses", pulses2 - base, 1);
        q2.push_back({4'hA, 1'b1, 1'b0});
        q2.push_back({4'hB, 1'b1, 1'b0});
        q2.push_back({4'hC, 1'b1, 1'b0});
        seg2 = glyph(10);
        step();
        seg2 = glyph(11);
        step();
        seg2 = glyph(12);
        repeat (6) step();
        check("dut2_fast_digit",  32'(dig2), 12);
        check("dut2_fast_pulses", pulses2 - base, 4);

        repeat (4) step();
        check("dut1_queue_drained", q1.size(), 0);
        check("dut2_queue_drained", q2.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule : tb_seg7_pattern_decoder
`default_nettype wire
